// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared word/address widths and the fetch FSM state type.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 8
`endif
package instruction_fetch_pkg;
    localparam int WORD_W = `WORD_SIZE;
    localparam int ADDR_W = `ADDR_BITS;
    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: single-outstanding memory read bus between fetch and memory.
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int WORD_SIZE = WORD_W,
    parameter int ADDR_BITS = ADDR_W
);
    logic                 mem_rd;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;
    modport master (output mem_rd, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_rd, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instruction_fetch_program_counter.sv
// instruction_fetch_program_counter: PC register with load (priority) and wrapping increment.
module instruction_fetch_program_counter
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_W,
    parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 inc,
    input  logic [ADDR_BITS-1:0] pc_in,
    output logic [ADDR_BITS-1:0] pc
);
    always_ff @(posedge clk or posedge rst)
        if (rst) pc <= RESET_PC;
        else if (load) pc <= pc_in;
        else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: reads the hi/lo words of an instruction at the PC and holds them for the decoder.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int WORD_SIZE = WORD_W,
    parameter int ADDR_BITS = ADDR_W,
    parameter logic [ADDR_BITS-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch,
    input  logic                 load_pc,
    input  logic [ADDR_BITS-1:0] pc_in,
    instruction_fetch_if.master  mem,
    output logic [WORD_SIZE-1:0] inst_hi,
    output logic [WORD_SIZE-1:0] inst_lo,
    output logic                 inst_valid,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 busy
);
    fetch_state_t state, state_nxt;
    logic idle, ack, pc_load;
    always_comb begin
        idle = state == IDLE;
        ack = !idle && mem.mem_ack;
        pc_load = idle && load_pc;
        busy = !idle;
        mem.mem_rd = !idle;
        mem.mem_addr = pc;
        state_nxt = idle ? (fetch ? REQ_HI : IDLE) : !ack ? state : state == REQ_HI ? REQ_LO : IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            inst_hi <= '0;
            inst_lo <= '0;
            inst_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (idle && (fetch || load_pc)) inst_valid <= 1'b0;
            if (ack && state == REQ_HI) inst_hi <= mem.mem_rdata;
            if (ack && state == REQ_LO) begin
                inst_lo <= mem.mem_rdata;
                inst_valid <= 1'b1;
            end
        end
    // Load and fetch in the same IDLE cycle both apply: REQ_HI reads the freshly loaded PC.
    instruction_fetch_program_counter #(.ADDR_BITS(ADDR_BITS), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .rst(rst),
        .load(pc_load),
        .inc(ack),
        .pc_in(pc_in),
        .pc(pc)
    );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized memory/wait-state bench against a word-level fetch model.
module tb_instruction_fetch;
    logic clk = 1'b0, rst = 1'b1, fetch = 1'b0, load_pc = 1'b0;
    logic [7:0] pc_in = 8'h00;
    logic [7:0] inst_hi, inst_lo, pc;
    logic inst_valid, busy;
    logic [7:0] mem_arr [256];
    logic [7:0] addr_q [$];
    logic [7:0] model_pc = 8'h00;
    int wait_cfg = 0, cnt = 0, checks = 0, errors = 0;
    bit idle_ack = 1'b0;

    instruction_fetch_if #(.WORD_SIZE(8), .ADDR_BITS(8)) bus ();
    instruction_fetch #(.WORD_SIZE(8), .ADDR_BITS(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .load_pc(load_pc), .pc_in(pc_in), .mem(bus),
        .inst_hi(inst_hi), .inst_lo(inst_lo), .inst_valid(inst_valid), .pc(pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory responds after wait_cfg wait cycles per read; idle_ack forces stray acks.
    assign bus.mem_ack = (bus.mem_rd && cnt >= wait_cfg) || idle_ack;
    assign bus.mem_rdata = bus.mem_ack ? mem_arr[bus.mem_addr] : 8'hEE;
    always @(posedge clk or posedge rst)
        if (rst) cnt <= 0;
        else if (bus.mem_rd && bus.mem_ack) cnt <= 0;
        else if (bus.mem_rd) cnt <= cnt + 1;
    always @(posedge clk) if (bus.mem_rd && bus.mem_ack) addr_q.push_back(bus.mem_addr);

    task automatic test_reset();
        #1;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h exp 00", pc); end
        checks++; if (inst_hi !== 8'h00 || inst_lo !== 8'h00) begin errors++; $display("FAIL reset_inst: got %h/%h exp 00/00", inst_hi, inst_lo); end
        checks++; if (inst_valid !== 1'b0 || bus.mem_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags: valid %b rd %b busy %b exp 0", inst_valid, bus.mem_rd, busy); end
        @(negedge clk) rst = 1'b0;
        model_pc = 8'h00;
    endtask

    task automatic run_fetch(input bit ld, input logic [7:0] tgt, input int w, input bit poke, input string name);
        logic [7:0] start, exp_hi, exp_lo, exp_pc, cur;
        int lat, exp_lat;
        bit poked;
        start = ld ? tgt : model_pc;
        exp_hi = mem_arr[start];
        exp_lo = mem_arr[8'(start + 8'd1)];
        exp_pc = 8'(start + 8'd2);
        exp_lat = 3 + 2 * w;
        wait_cfg = w;
        addr_q.delete();
        poked = 1'b0;
        @(negedge clk);
        fetch = 1'b1; load_pc = ld; pc_in = tgt;
        @(negedge clk);
        fetch = 1'b0; load_pc = 1'b0; lat = 1;
        while (!inst_valid && lat < 40) begin
            cur = (addr_q.size() == 0) ? start : 8'(start + 8'd1);
            checks++;
            if (bus.mem_rd !== 1'b1 || bus.mem_addr !== cur) begin
                errors++; $display("FAIL %s rd_addr: got rd %b addr %h exp rd 1 addr %h", name, bus.mem_rd, bus.mem_addr, cur);
            end
            if (poke && !poked && addr_q.size() == 1) begin
                fetch = 1'b1; load_pc = 1'b1; pc_in = ~start; poked = 1'b1;
            end
            @(negedge clk);
            fetch = 1'b0; load_pc = 1'b0; lat++;
        end
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d exp %0d", name, lat, exp_lat); end
        checks++; if (inst_hi !== exp_hi || inst_lo !== exp_lo) begin errors++; $display("FAIL %s inst: got %h/%h exp %h/%h", name, inst_hi, inst_lo, exp_hi, exp_lo); end
        checks++; if (pc !== exp_pc || busy !== 1'b0) begin errors++; $display("FAIL %s pc_busy: got %h/%b exp %h/0", name, pc, busy, exp_pc); end
        checks++;
        if (addr_q.size() != 2 || addr_q[0] !== start || addr_q[1] !== 8'(start + 8'd1)) begin
            errors++; $display("FAIL %s reads: got %0d reads first %h exp 2 reads %h,%h", name, addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 8'hxx, start, 8'(start + 8'd1));
        end
        if (poke) begin
            repeat (3) @(negedge clk);
            checks++;
            if (busy !== 1'b0 || addr_q.size() != 2 || pc !== exp_pc || inst_valid !== 1'b1) begin
                errors++; $display("FAIL %s ignored: got busy %b reads %0d pc %h valid %b exp 0/2/%h/1", name, busy, addr_q.size(), pc, inst_valid, exp_pc);
            end
        end
        model_pc = exp_pc;
    endtask

    task automatic test_idle_hold();
        logic [7:0] hi0, lo0, pc0;
        hi0 = inst_hi; lo0 = inst_lo; pc0 = pc;
        idle_ack = 1'b1;
        repeat (4) begin @(negedge clk); pc_in = 8'($urandom); end
        idle_ack = 1'b0;
        checks++;
        if (inst_hi !== hi0 || inst_lo !== lo0 || pc !== pc0 || inst_valid !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_hold: got %h/%h pc %h valid %b busy %b exp %h/%h pc %h valid 1 busy 0", inst_hi, inst_lo, pc, inst_valid, busy, hi0, lo0, pc0);
        end
    endtask

    task automatic test_load_only(input logic [7:0] tgt);
        @(negedge clk);
        load_pc = 1'b1; pc_in = tgt;
        @(negedge clk);
        load_pc = 1'b0;
        checks++;
        if (pc !== tgt || inst_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL load_only: got pc %h valid %b busy %b exp %h/0/0", pc, inst_valid, busy, tgt);
        end
        model_pc = tgt;
    endtask

    task automatic test_reset_mid();
        test_load_only(8'h10);
        wait_cfg = 1000;
        @(negedge clk) fetch = 1'b1;
        @(negedge clk) fetch = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h10) begin errors++; $display("FAIL stall: got rd %b addr %h exp 1/10", bus.mem_rd, bus.mem_addr); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.mem_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_rst_rd: got rd %b busy %b exp 0/0", bus.mem_rd, busy); end
        checks++; if (pc !== 8'h00 || inst_valid !== 1'b0 || inst_hi !== 8'h00 || inst_lo !== 8'h00) begin errors++; $display("FAIL async_rst_state: got pc %h valid %b inst %h/%h exp 00/0/00/00", pc, inst_valid, inst_hi, inst_lo); end
        @(negedge clk) rst = 1'b0;
        wait_cfg = 0;
        model_pc = 8'h00;
        run_fetch(1'b0, 8'h00, 0, 1'b0, "after_rst");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
        mem_arr[8'h00] = 8'h12; mem_arr[8'h01] = 8'h34;
        mem_arr[8'h40] = 8'hA5; mem_arr[8'h41] = 8'h5A;
        mem_arr[8'hFF] = 8'h88;
        test_reset();
        run_fetch(1'b0, 8'h00, 0, 1'b0, "basic");
        run_fetch(1'b1, 8'h00, 2, 1'b0, "wait2");
        run_fetch(1'b1, 8'h40, 0, 1'b0, "load_fetch");
        test_idle_hold();
        mem_arr[8'h00] = 8'h01;
        test_load_only(8'hFF);
        run_fetch(1'b0, 8'h00, 0, 1'b0, "wrap");
        run_fetch(1'b0, 8'h00, 1, 1'b1, "busy_ignore");
        test_reset_mid();
        for (int i = 0; i < 12; i++) begin
            mem_arr[$urandom_range(0, 255)] = 8'($urandom);
            run_fetch(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Reads the two consecutive memory words of an OrgaSmall instruction at the PC: high word first, then low word.
- Holds them in inst_hi/inst_lo for the decoder and advances the PC by 2.
- Accepts PC loads from the execute stage for jumps and calls.

Parameters:
- WORD_SIZE, `WORD_SIZE (8), width of a memory word and of inst_hi/inst_lo.
- ADDR_BITS, `ADDR_BITS (8), PC and memory address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch  in  1  request to fetch the next instruction; sampled only in IDLE.
- load_pc  in  1  load pc_in into the PC; sampled only in IDLE.
- pc_in  in  ADDR_BITS  jump target.
- mem_rd  out  1  memory read request.
- mem_addr  out  ADDR_BITS  read address.
- mem_rdata  in  WORD_SIZE  read data; valid when mem_ack=1.
- mem_ack  in  1  read completes this cycle.
- inst_hi  out  WORD_SIZE  instruction high word, to the decoder.
- inst_lo  out  WORD_SIZE  instruction low word, to the decoder.
- inst_valid  out  1  inst_hi/inst_lo hold a complete, current instruction.
- pc  out  ADDR_BITS  address of the next instruction to fetch.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (asynchronous, immediate, including mid-fetch):
  - state=IDLE, pc=RESET_PC, inst_hi=inst_lo=0, inst_valid=0, mem_rd=0.
  - mem_addr is a don't-care; drive pc.
- States: IDLE, REQ_HI, REQ_LO. The state encoding is an enum.
- IDLE:
  - mem_rd=0, busy=0.
  - load_pc=1: pc<=pc_in, inst_valid<=0.
  - fetch=1: inst_valid<=0, next state REQ_HI.
  - load_pc and fetch both high: apply both. The PC is loaded and the fetch proceeds from the new pc_in, because REQ_HI reads the registered pc.
- REQ_HI:
  - mem_rd=1, mem_addr=pc.
  - On mem_ack: inst_hi<=mem_rdata, pc<=pc+1, next state REQ_LO.
  - Without ack: hold mem_rd and mem_addr stable, wait indefinitely.
- REQ_LO:
  - mem_rd=1, mem_addr=pc (already incremented).
  - On mem_ack: inst_lo<=mem_rdata, pc<=pc+1, inst_valid<=1, next state IDLE.
- Latency: minimum 3 cycles from fetch accepted (cycle 0) to inst_valid=1, with zero-wait acks in cycles 1 and 2. Each wait cycle adds 1.
- inst_valid, inst_hi and inst_lo stay stable in IDLE until the next accepted fetch or load_pc. The decoder output is therefore stable for the execute stage.
- inst_hi is updated during REQ_HI, but inst_valid=0 then, so consumers ignore it.
- PC arithmetic is modulo 2^ADDR_BITS. An instruction at 0xFF takes its hi word from 0xFF and its lo word from 0x00, and the PC then equals 0x01.
- fetch and load_pc asserted while busy are ignored (not queued).
- mem_ack in IDLE is ignored.
- mem_rdata is sampled only in a cycle with mem_rd=1 and mem_ack=1.

Decomposition:
- Add `ADDR_BITS (8) to the shared config header alongside `WORD_SIZE and the other width macros.
- Put the fetch-state enum typedef there as well so the future control unit can reference it.
- One natural sub-module, program_counter:
  - ADDR_BITS register with async reset to RESET_PC.
  - Controls: load (pc_in) and inc (+1, wrapping).
  - load has priority over inc.
- The FSM and instruction registers stay in instruction_fetch.

Test Plan:
- Reset release, memory[0]=0x12 and [1]=0x34, zero-wait ack, pulse fetch:
  - mem_addr 0x00 then 0x01.
  - inst_valid rises 3 cycles after fetch.
  - inst_hi=0x12, inst_lo=0x34, pc=0x02.
- Same stimulus but mem_ack delayed 2 cycles on each read:
  - mem_rd and mem_addr held stable while waiting.
  - inst_valid after 7 cycles; values unchanged.
- load_pc with pc_in=0x40 and fetch in the same IDLE cycle, memory[0x40]=0xA5, [0x41]=0x5A:
  - reads hit 0x40 and 0x41.
  - inst_hi=0xA5, inst_lo=0x5A, pc=0x42.
- load_pc with pc_in=0xFF then fetch, memory[0xFF]=0x88, [0x00]=0x01:
  - addresses 0xFF then 0x00.
  - inst_hi=0x88, inst_lo=0x01, pc=0x01.
- load_pc=1 and fetch=1 pulsed during REQ_LO: ignored; pc ends at old pc+2, and no second fetch starts.
- Assert rst during a stalled REQ_HI at pc=0x10:
  - mem_rd drops without waiting for a clock.
  - pc=0, inst_valid=0, state IDLE.
  - A subsequent fetch reads from 0x00.
